// File: rtl/bh1750_lux_bcd_if.sv
// Reading-side and result-side signals between the BH1750 master and the lux/BCD converter.
interface bh1750_lux_bcd_if;
  logic        busy_in;
  logic [15:0] raw_in;
  logic [15:0] lux;
  logic [19:0] bcd;
  logic        valid;
  logic        conv_busy;
  logic        ovr;

  modport master (output busy_in, raw_in, input lux, bcd, valid, conv_busy, ovr);
  modport slave  (input busy_in, raw_in, output lux, bcd, valid, conv_busy, ovr);
endinterface

// File: rtl/bh1750_lux_bcd.sv
// Converts each completed BH1750 raw count to integer lux and 5 packed BCD digits
// using a sequential multiply, restoring divide and double-dabble.
//
// state | meaning
// IDLE  | waiting for a busy_in fall
// MUL   | build dividend raw*5 (+ rounding bias)
// DIV   | 19 cycles of restoring division, one quotient bit per cycle
// BCD   | 16 cycles of double-dabble on the quotient
// DONE  | results published, valid high
module bh1750_lux_bcd #(
  parameter bit HRES2 = 1'b1,
  parameter bit ROUND = 1'b0
) (
  input logic              sys_clk,
  input logic              _rst,
  bh1750_lux_bcd_if.slave  bus
);

  localparam logic [3:0]  DIVISOR = HRES2 ? 4'd12 : 4'd6;
  localparam logic [18:0] BIAS    = ROUND ? {15'd0, 1'b0, DIVISOR[3:1]} : 19'd0;

  typedef enum logic [2:0] {IDLE, MUL, DIV, BCD, DONE} state_t;

  state_t      state, next_state;
  logic        sync1, sync2, busy_q;
  logic        fall, tc;
  logic [15:0] raw_q;
  logic [18:0] acc;
  logic [3:0]  rem;
  logic [15:0] quot;
  logic [15:0] bin;
  logic [19:0] bcd_r;
  logic [4:0]  cnt;
  logic [15:0] lux_r;
  logic [19:0] bcd_o;
  logic        valid_r, conv_busy_r, ovr_r;

  logic [4:0]  trial;
  logic        ge;
  logic [3:0]  rem_next;
  logic [18:0] acc_next;
  logic [19:0] bcd_adj;
  logic [19:0] bcd_next;

  assign fall = ~sync2 & busy_q;
  assign tc   = (cnt == 5'd0);

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      busy_q <= 1'b1;
    end else begin
      sync1  <= bus.busy_in;
      sync2  <= sync1;
      busy_q <= sync2;
    end
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fall) next_state = MUL;
      MUL:     next_state = DIV;
      DIV:     if (tc) next_state = BCD;
      BCD:     if (tc) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Remainder stays below the divisor, so the 5-bit trial never exceeds 23.
  always_comb begin
    trial    = {rem, acc[18]};
    ge       = (trial >= {1'b0, DIVISOR});
    rem_next = ge ? 4'(trial - {1'b0, DIVISOR}) : trial[3:0];
    acc_next = {acc[17:0], ge};
  end

  always_comb begin
    bcd_adj = bcd_r;
    for (int d = 0; d < 5; d++) begin
      if (bcd_r[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_r[d*4 +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[18:0], bin[15]};
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      raw_q       <= '0;
      acc         <= '0;
      rem         <= '0;
      quot        <= '0;
      bin         <= '0;
      bcd_r       <= '0;
      cnt         <= '0;
      lux_r       <= '0;
      bcd_o       <= '0;
      valid_r     <= 1'b0;
      conv_busy_r <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      ovr_r   <= fall && (state != IDLE);
      case (state)
        IDLE: begin
          if (fall) begin
            raw_q       <= bus.raw_in;
            conv_busy_r <= 1'b1;
          end
        end
        MUL: begin
          acc <= ({3'd0, raw_q} << 2) + {3'd0, raw_q} + BIAS;
          rem <= '0;
          cnt <= 5'd18;
        end
        DIV: begin
          acc <= acc_next;
          rem <= rem_next;
          cnt <= cnt - 5'd1;
          if (tc) begin
            quot  <= acc_next[15:0];
            bin   <= acc_next[15:0];
            bcd_r <= '0;
            cnt   <= 5'd15;
          end
        end
        BCD: begin
          bcd_r <= bcd_next;
          bin   <= {bin[14:0], 1'b0};
          cnt   <= cnt - 5'd1;
          if (tc) begin
            lux_r       <= quot;
            bcd_o       <= bcd_next;
            valid_r     <= 1'b1;
            conv_busy_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.lux       = lux_r;
  assign bus.bcd       = bcd_o;
  assign bus.valid     = valid_r;
  assign bus.conv_busy = conv_busy_r;
  assign bus.ovr       = ovr_r;

endmodule
